// File: rtl/demux1to2_32bit_stream_pkg.sv
// Shared defaults and slot-state encoding for the 1-to-2 stream demultiplexer.
package demux1to2_32bit_stream_pkg;

   localparam int WIDTH_DEF     = 32;
   localparam int CNT_WIDTH_DEF = 16;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

endpackage

// File: rtl/demux1to2_32bit_stream_if.sv
// Handshake bundle between the input source, the demux and its two output sinks.
interface demux1to2_32bit_stream_if #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 16
);
   logic [WIDTH-1:0]     In_Data;
   logic                 In_Sel;
   logic                 In_Valid;
   logic                 In_Ready;
   logic [WIDTH-1:0]     Out0_Data;
   logic                 Out0_Valid;
   logic                 Out0_Ready;
   logic [WIDTH-1:0]     Out1_Data;
   logic                 Out1_Valid;
   logic                 Out1_Ready;
   logic [CNT_WIDTH-1:0] Count0;
   logic [CNT_WIDTH-1:0] Count1;

   modport slave (
      input  In_Data, In_Sel, In_Valid, Out0_Ready, Out1_Ready,
      output In_Ready, Out0_Data, Out0_Valid, Out1_Data, Out1_Valid, Count0, Count1
   );

   modport master (
      output In_Data, In_Sel, In_Valid, Out0_Ready, Out1_Ready,
      input  In_Ready, Out0_Data, Out0_Valid, Out1_Data, Out1_Valid, Count0, Count1
   );
endinterface

// File: rtl/demux1to2_32bit_stream_slot.sv
// Single-entry output slot: data register, EMPTY/FULL state flop and a wrapping
// delivered-word counter. Can_Load says the slot may be written this cycle.
module demux_out_slot
   import demux1to2_32bit_stream_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Load,
   input  logic [WIDTH-1:0]     Load_Data,
   input  logic                 Out_Ready,
   output logic [WIDTH-1:0]     Out_Data,
   output logic                 Out_Valid,
   output logic [CNT_WIDTH-1:0] Count,
   output logic                 Can_Load
);

   slot_state_e          state_r;
   slot_state_e          state_nxt_s;
   logic [WIDTH-1:0]     data_r;
   logic [CNT_WIDTH-1:0] count_r;
   logic                 drain_s;

   // Drain/load qualification and next slot state
   always_comb begin
      drain_s     = 1'b0;
      can_load_default();
      state_nxt_s = state_r;
      case (state_r)
         SLOT_EMPTY: begin
            if (Load) state_nxt_s = SLOT_FULL;
            else      state_nxt_s = SLOT_EMPTY;
         end
         SLOT_FULL: begin
            drain_s = Out_Ready;
            if (Load)           state_nxt_s = SLOT_FULL;
            else if (Out_Ready) state_nxt_s = SLOT_EMPTY;
            else                state_nxt_s = SLOT_FULL;
         end
         default: state_nxt_s = SLOT_EMPTY;
      endcase
      Can_Load = (state_r == SLOT_EMPTY) | drain_s;
   end

   function automatic void can_load_default();
   endfunction

   // Slot state register
   always_ff @(posedge Clk) begin
      if (Reset) state_r <= SLOT_EMPTY;
      else       state_r <= state_nxt_s;
   end

   // Data register; a load while draining replaces the outgoing word
   always_ff @(posedge Clk) begin
      if (Reset)     data_r <= {WIDTH{1'b0}};
      else if (Load) data_r <= Load_Data;
      else           data_r <= data_r;
   end

   // Delivered-word counter, wraps silently
   always_ff @(posedge Clk) begin
      if (Reset)        count_r <= {CNT_WIDTH{1'b0}};
      else if (drain_s) count_r <= count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      else              count_r <= count_r;
   end

   assign Out_Data  = data_r;
   assign Out_Valid = (state_r == SLOT_FULL);
   assign Count     = count_r;

endmodule

// File: rtl/demux1to2_32bit_stream.sv
// Registered 1-to-2 stream demultiplexer: In_Sel steers each accepted word into
// one of two independent single-entry output slots.
module demux1to2_32bit_stream
   import demux1to2_32bit_stream_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic                   Clk,
   input  logic                   Reset,
   demux1to2_32bit_stream_if.slave bus
);

   logic can_load0_s;
   logic can_load1_s;
   logic in_ready_s;
   logic load0_s;
   logic load1_s;

   // Ready follows only the targeted slot, so a stalled channel never blocks the other
   always_comb begin
      in_ready_s = 1'b0;
      load0_s    = 1'b0;
      load1_s    = 1'b0;
      if (Reset) begin
         in_ready_s = 1'b0;
      end else begin
         if (bus.In_Sel) in_ready_s = can_load1_s;
         else            in_ready_s = can_load0_s;
      end
      load0_s = bus.In_Valid & in_ready_s & ~bus.In_Sel;
      load1_s = bus.In_Valid & in_ready_s &  bus.In_Sel;
   end

   assign bus.In_Ready = in_ready_s;

   demux_out_slot #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_slot0 (
      .Clk       (Clk),
      .Reset     (Reset),
      .Load      (load0_s),
      .Load_Data (bus.In_Data),
      .Out_Ready (bus.Out0_Ready),
      .Out_Data  (bus.Out0_Data),
      .Out_Valid (bus.Out0_Valid),
      .Count     (bus.Count0),
      .Can_Load  (can_load0_s)
   );

   demux_out_slot #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_slot1 (
      .Clk       (Clk),
      .Reset     (Reset),
      .Load      (load1_s),
      .Load_Data (bus.In_Data),
      .Out_Ready (bus.Out1_Ready),
      .Out_Data  (bus.Out1_Data),
      .Out_Valid (bus.Out1_Valid),
      .Count     (bus.Count1),
      .Can_Load  (can_load1_s)
   );

endmodule

// File: tb/tb_demux1to2_32bit_stream.sv
// Scoreboard bench for the 1-to-2 stream demux; a second instance with a 4-bit
// counter exercises counter wrap.
module tb_demux1to2_32bit_stream;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   demux1to2_32bit_stream_if #(.WIDTH(32), .CNT_WIDTH(16)) b ();
   demux1to2_32bit_stream_if #(.WIDTH(32), .CNT_WIDTH(4))  bc ();

   demux1to2_32bit_stream #(.WIDTH(32), .CNT_WIDTH(16)) dut (
      .Clk(clk), .Reset(rst), .bus(b)
   );
   demux1to2_32bit_stream #(.WIDTH(32), .CNT_WIDTH(4)) dut_c (
      .Clk(clk), .Reset(rst), .bus(bc)
   );

   int checks = 0;
   int errors = 0;
   logic mon_en = 1'b0;
   logic [31:0] q0[$];
   logic [31:0] q1[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a word and hold it until accepted; expected word queued at acceptance
   task automatic send(input logic [31:0] d, input logic s, output int waited);
      b.In_Data  = d;
      b.In_Sel   = s;
      b.In_Valid = 1'b1;
      waited     = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (b.In_Ready === 1'b1) begin
            if (s) q1.push_back(d);
            else   q0.push_back(d);
            @(posedge clk);
            #1;
            b.In_Valid = 1'b0;
            return;
         end
         waited++;
      end
      check("send_timeout", 32'd1, 32'd0);
      b.In_Valid = 1'b0;
   endtask

   // Monitor: every drain must match the oldest expected word of that channel
   always @(negedge clk) begin
      if (mon_en) begin
         if (b.Out0_Valid === 1'b1 && b.Out0_Ready === 1'b1) begin
            if (q0.size() == 0) check("ch0_unexpected_word", b.Out0_Data, 32'hxxxxxxxx);
            else                check("ch0_data", b.Out0_Data, q0.pop_front());
         end
         if (b.Out1_Valid === 1'b1 && b.Out1_Ready === 1'b1) begin
            if (q1.size() == 0) check("ch1_unexpected_word", b.Out1_Data, 32'hxxxxxxxx);
            else                check("ch1_data", b.Out1_Data, q1.pop_front());
         end
      end
   end

   task automatic pulse_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int w;
      int acc;
      int drn;
      logic d_s;
      logic a_s;
      logic [31:0] exp_w;

      b.In_Data = 32'h0; b.In_Sel = 1'b0; b.In_Valid = 1'b0;
      b.Out0_Ready = 1'b1; b.Out1_Ready = 1'b1;
      bc.In_Data = 32'h0; bc.In_Sel = 1'b1; bc.In_Valid = 1'b0;
      bc.Out0_Ready = 1'b1; bc.Out1_Ready = 1'b1;

      // Initial reset: slots are empty after the first edge, ready must still be low
      rst = 1'b1;
      step();
      check("ready_in_reset", {31'd0, b.In_Ready}, 32'd0);
      step();
      rst = 1'b0;
      check("rst_v0", {31'd0, b.Out0_Valid}, 32'd0);
      check("rst_v1", {31'd0, b.Out1_Valid}, 32'd0);
      check("rst_d0", b.Out0_Data, 32'd0);
      check("rst_d1", b.Out1_Data, 32'd0);
      check("rst_c0", {16'd0, b.Count0}, 32'd0);
      check("rst_c1", {16'd0, b.Count1}, 32'd0);
      mon_en = 1'b1;

      // Single word to channel 0
      send(32'h12345678, 1'b0, w);
      check("t1_v0_after_load", {31'd0, b.Out0_Valid}, 32'd1);
      step();
      check("t1_v0_one_cycle", {31'd0, b.Out0_Valid}, 32'd0);
      check("t1_c0", {16'd0, b.Count0}, 32'd1);
      check("t1_c1", {16'd0, b.Count1}, 32'd0);

      // Single word to channel 1
      send(32'hFEDCBA98, 1'b1, w);
      check("t2_v1_after_load", {31'd0, b.Out1_Valid}, 32'd1);
      check("t2_v0_idle", {31'd0, b.Out0_Valid}, 32'd0);
      step();
      check("t2_c1", {16'd0, b.Count1}, 32'd1);
      check("t2_v1_one_cycle", {31'd0, b.Out1_Valid}, 32'd0);

      // Stalled channel 0 blocks only words aimed at it
      pulse_reset();
      b.Out0_Ready = 1'b0;
      send(32'h00000000, 1'b0, w);
      b.In_Data = 32'h11111111; b.In_Sel = 1'b0; b.In_Valid = 1'b1;
      #1;
      check("t3_ready_blocked", {31'd0, b.In_Ready}, 32'd0);
      step();
      check("t3_hold_data", b.Out0_Data, 32'h00000000);
      check("t3_hold_valid", {31'd0, b.Out0_Valid}, 32'd1);
      send(32'h11111111, 1'b1, w);
      check("t3_ch1_no_wait", w, 32'd0);
      step();
      b.Out0_Ready = 1'b1;
      step();
      check("t3_c0", {16'd0, b.Count0}, 32'd1);
      check("t3_c1", {16'd0, b.Count1}, 32'd1);
      check("t3_v0_drained", {31'd0, b.Out0_Valid}, 32'd0);

      // Back-to-back alternating stream
      pulse_reset();
      for (int i = 0; i < 8; i++) begin
         send(32'hA5000000 + i, i[0], w);
         check("t4_no_stall", w, 32'd0);
      end
      step();
      step();
      check("t4_c0", {16'd0, b.Count0}, 32'd4);
      check("t4_c1", {16'd0, b.Count1}, 32'd4);

      // Reset with both slots full and stalled
      b.Out0_Ready = 1'b0; b.Out1_Ready = 1'b0;
      send(32'hAAAA5555, 1'b0, w);
      send(32'h5555AAAA, 1'b1, w);
      check("t5_full0", {31'd0, b.Out0_Valid}, 32'd1);
      check("t5_full1", {31'd0, b.Out1_Valid}, 32'd1);
      rst = 1'b1;
      b.In_Data = 32'h77777777; b.In_Sel = 1'b0; b.In_Valid = 1'b1;
      #1;
      check("t5_ready_in_reset", {31'd0, b.In_Ready}, 32'd0);
      q0.delete();
      q1.delete();
      step();
      rst = 1'b0;
      b.In_Valid = 1'b0;
      check("t5_v0", {31'd0, b.Out0_Valid}, 32'd0);
      check("t5_v1", {31'd0, b.Out1_Valid}, 32'd0);
      check("t5_d0", b.Out0_Data, 32'd0);
      check("t5_d1", b.Out1_Data, 32'd0);
      check("t5_c0", {16'd0, b.Count0}, 32'd0);
      check("t5_c1", {16'd0, b.Count1}, 32'd0);
      #1;
      check("t5_ready_after", {31'd0, b.In_Ready}, 32'd1);
      b.Out0_Ready = 1'b1; b.Out1_Ready = 1'b1;

      // 4-bit counter wrap on channel 1 of the second instance
      acc = 0;
      drn = 0;
      bc.In_Sel   = 1'b1;
      bc.In_Data  = 32'hC0000000;
      bc.In_Valid = 1'b1;
      for (int cyc = 0; cyc < 60 && drn < 17; cyc++) begin
         @(negedge clk);
         a_s = bc.In_Valid & bc.In_Ready;
         d_s = bc.Out1_Valid & bc.Out1_Ready;
         if (d_s === 1'b1) begin
            exp_w = 32'hC0000000 + drn;
            check("t6_data", bc.Out1_Data, exp_w);
         end
         @(posedge clk);
         #1;
         if (a_s === 1'b1) begin
            acc++;
            bc.In_Data = 32'hC0000000 + acc;
            if (acc == 17) bc.In_Valid = 1'b0;
         end
         if (d_s === 1'b1) begin
            drn++;
            exp_w = drn % 16;
            check("t6_count1", {28'd0, bc.Count1}, exp_w);
         end
      end
      check("t6_drained_17", drn, 32'd17);
      bc.In_Valid = 1'b0;

      step();
      check("sb_q0_empty", q0.size(), 32'd0);
      check("sb_q1_empty", q1.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
